// File: rtl/fetch_sequencer_if.sv
// Control bundle between the fetch sequencer and the datapath / memory / execute unit.
//   master : the fetch sequencer; samples run/ir_opcode/zero_flag/mem_ready/exec_done
//            and drives every bus/strobe control line.
//   slave  : the datapath side; drives the status lines, samples the controls.
interface fetch_sequencer_if;
    logic       run;
    logic [7:0] ir_opcode;
    logic       zero_flag;
    logic       mem_ready;
    logic       exec_done;

    logic       PC_write;
    logic       PC_read;
    logic       counter_enable;
    logic       MAR_read;
    logic       mem_req;
    logic       RAM_write;
    logic       IR_read;
    logic       IR_operand_write;
    logic       exec_start;
    logic       halted;
    logic       fault;

    modport master (
        input  run, ir_opcode, zero_flag, mem_ready, exec_done,
        output PC_write, PC_read, counter_enable, MAR_read, mem_req, RAM_write,
               IR_read, IR_operand_write, exec_start, halted, fault
    );

    modport slave (
        output run, ir_opcode, zero_flag, mem_ready, exec_done,
        input  PC_write, PC_read, counter_enable, MAR_read, mem_req, RAM_write,
               IR_read, IR_operand_write, exec_start, halted, fault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch / decode sequencer. Walks F_ADDR -> F_WAIT -> F_DATA -> DECODE and then
// JUMP, EXEC, HALT or FAULT, emitting Moore-decoded bus strobes for the datapath.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; forces IDLE and all outputs low immediately
//   bus   : fetch_sequencer_if.master (status inputs in, control strobes out)
module fetch_sequencer #(
    parameter logic [7:0]  OPC_JMP  = 8'h10,
    parameter logic [7:0]  OPC_JZ   = 8'h11,
    parameter logic [7:0]  OPC_HLT  = 8'hFF,
    parameter int unsigned WAIT_MAX = 15    // legal 1..255
) (
    input logic               clk,
    input logic               reset,
    fetch_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        StIdle, StFAddr, StFWait, StFData, StDecode, StExec, StJump, StHalt, StFault
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       exec_first_q, exec_first_d;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wait_q       <= 8'd0;
            exec_first_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            exec_first_q <= exec_first_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        wait_d  = 8'd0;     // counter is zero on every entry into F_WAIT
        unique case (state_q)
            StIdle:   if (bus.run) state_d = StFAddr;
            StFAddr:  state_d = StFWait;
            StFWait: begin
                if (bus.mem_ready) begin
                    // Ready wins even on the cycle the counter would expire.
                    state_d = StFData;
                end else if (wait_q == 8'(WAIT_MAX - 1)) begin
                    state_d = StFault;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StFData:  state_d = StDecode;
            StDecode: begin
                if (bus.ir_opcode == OPC_HLT) begin
                    state_d = StHalt;
                end else if (bus.ir_opcode == OPC_JMP ||
                             (bus.ir_opcode == OPC_JZ && bus.zero_flag)) begin
                    state_d = StJump;
                end else begin
                    state_d = StExec;
                end
            end
            StJump:   state_d = bus.run ? StFAddr : StIdle;
            StExec:   if (bus.exec_done) state_d = bus.run ? StFAddr : StIdle;
            StHalt:   state_d = StHalt;
            StFault:  state_d = StFault;
            default:  state_d = StIdle;
        endcase
        // Marks the first EXEC cycle so exec_start is a single pulse.
        exec_first_d = (state_d == StExec) && (state_q != StExec);
    end

    // Output decode
    always_comb begin
        bus.PC_write         = 1'b0;
        bus.PC_read          = 1'b0;
        bus.counter_enable   = 1'b0;
        bus.MAR_read         = 1'b0;
        bus.mem_req          = 1'b0;
        bus.RAM_write        = 1'b0;
        bus.IR_read          = 1'b0;
        bus.IR_operand_write = 1'b0;
        bus.exec_start       = 1'b0;
        bus.halted           = 1'b0;
        bus.fault            = 1'b0;
        unique case (state_q)
            StFAddr: begin
                bus.PC_write = 1'b1;
                bus.MAR_read = 1'b1;
            end
            StFWait: bus.mem_req = 1'b1;
            StFData: begin
                bus.RAM_write      = 1'b1;
                bus.IR_read        = 1'b1;
                bus.counter_enable = 1'b1;
            end
            StJump: begin
                bus.IR_operand_write = 1'b1;
                bus.PC_read          = 1'b1;
            end
            StExec:  bus.exec_start = exec_first_q;
            StHalt:  bus.halted     = 1'b1;
            StFault: bus.fault      = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer. The driver builds each instruction from a high-level
// descriptor (opcode, zero flag, memory wait, exec length, run decision, idle gap), drives the
// matching per-cycle inputs and queues the output vector each cycle must show. A separate
// monitor pops one vector per cycle and also checks the bus invariants every cycle.
module tb_fetch_sequencer;

    localparam int unsigned WAIT_MAX = 15;
    localparam logic [7:0]  OPC_JMP  = 8'h10;
    localparam logic [7:0]  OPC_JZ   = 8'h11;
    localparam logic [7:0]  OPC_HLT  = 8'hFF;

    // Output vector bit positions
    localparam int B_PCW = 10, B_PCR = 9, B_CE = 8, B_MAR = 7, B_MREQ = 6, B_RAMW = 5;
    localparam int B_IRR = 4, B_IROW = 3, B_XS = 2, B_HLT = 1, B_FLT = 0;

    localparam logic [10:0] V_ZERO  = 11'd0;
    localparam logic [10:0] V_FADDR = (11'd1 << B_PCW) | (11'd1 << B_MAR);
    localparam logic [10:0] V_FWAIT = (11'd1 << B_MREQ);
    localparam logic [10:0] V_FDATA = (11'd1 << B_RAMW) | (11'd1 << B_IRR) | (11'd1 << B_CE);
    localparam logic [10:0] V_JUMP  = (11'd1 << B_IROW) | (11'd1 << B_PCR);
    localparam logic [10:0] V_EXEC1 = (11'd1 << B_XS);
    localparam logic [10:0] V_HALT  = (11'd1 << B_HLT);
    localparam logic [10:0] V_FAULT = (11'd1 << B_FLT);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .OPC_JMP  (OPC_JMP),
        .OPC_JZ   (OPC_JZ),
        .OPC_HLT  (OPC_HLT),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wire [10:0] obs = {bus.PC_write, bus.PC_read, bus.counter_enable, bus.MAR_read, bus.mem_req,
                       bus.RAM_write, bus.IR_read, bus.IR_operand_write, bus.exec_start,
                       bus.halted, bus.fault};

    logic [10:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int cycle_n  = 0;

    // Monitor: samples mid-low-phase, after the driver has queued this cycle's expectation.
    always begin
        logic [10:0] e;
        @(negedge clk);
        #2;
        cycle_n++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL outputs cycle=%0d got=%b expected=%b", cycle_n, obs, e);
            end
        end
        checks++;
        if ($countones({bus.PC_write, bus.RAM_write, bus.IR_operand_write}) > 1) begin
            failures++;
            $display("FAIL bus_exclusive cycle=%0d got PCW/RAMW/IROW=%b required at most one",
                     cycle_n, {bus.PC_write, bus.RAM_write, bus.IR_operand_write});
        end
        checks++;
        if (bus.PC_read && bus.counter_enable) begin
            failures++;
            $display("FAIL pcread_vs_ce cycle=%0d got both 1 required not both", cycle_n);
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] ropc();
        return 8'($urandom);
    endfunction

    // One clock cycle: drive inputs and queue the outputs this cycle must show.
    task automatic cyc(input logic [10:0] exp, input logic r, input logic mr, input logic ed,
                       input logic [7:0] opc, input logic z);
        @(negedge clk);
        bus.run       = r;
        bus.mem_ready = mr;
        bus.exec_done = ed;
        bus.ir_opcode = opc;
        bus.zero_flag = z;
        exp_q.push_back(exp);
    endtask

    // g IDLE cycles, run raised only in the last one.
    task automatic idle(input int g);
        for (int k = 1; k <= g; k++) cyc(V_ZERO, (k == g), rb(), rb(), ropc(), rb());
    endtask

    // One instruction starting in F_ADDR. w: wait cycles before ready (>= WAIT_MAX means
    // never ready), e: EXEC length, r: run at the exit point, g: idle gap when r=0.
    task automatic do_instr(input logic [7:0] opc, input logic z, input int w, input int e,
                            input logic r, input int g, output bit stop);
        stop = 0;
        cyc(V_FADDR, rb(), rb(), rb(), ropc(), rb());
        if (w >= int'(WAIT_MAX)) begin
            for (int k = 1; k <= int'(WAIT_MAX); k++) cyc(V_FWAIT, rb(), 1'b0, rb(), ropc(), rb());
            for (int k = 0; k < 4; k++) cyc(V_FAULT, rb(), rb(), rb(), ropc(), rb());
            stop = 1;
            return;
        end
        for (int k = 1; k <= w + 1; k++) cyc(V_FWAIT, rb(), (k == w + 1), rb(), ropc(), rb());
        cyc(V_FDATA, rb(), rb(), rb(), ropc(), rb());
        cyc(V_ZERO, rb(), rb(), rb(), opc, z);
        if (opc == OPC_HLT) begin
            for (int k = 0; k < 4; k++) cyc(V_HALT, rb(), rb(), rb(), ropc(), rb());
            stop = 1;
            return;
        end
        if (opc == OPC_JMP || (opc == OPC_JZ && z)) begin
            cyc(V_JUMP, r, rb(), rb(), ropc(), rb());
        end else begin
            for (int k = 1; k <= e; k++)
                cyc((k == 1) ? V_EXEC1 : V_ZERO, (k == e) ? r : rb(), rb(), (k == e),
                    ropc(), rb());
        end
        if (!r) idle(g);
    endtask

    // Asynchronous reset mid-cycle; outputs must drop before the next edge.
    task automatic async_reset(input string name);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== V_ZERO) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, obs, V_ZERO);
        end
        cyc(V_ZERO, 1'b1, rb(), rb(), ropc(), rb());
        cyc(V_ZERO, 1'b0, rb(), rb(), ropc(), rb());
        reset = 1'b0;
        idle(1 + $urandom_range(0, 2));
    endtask

    task automatic rand_instr(output bit stop);
        logic [7:0] opc;
        int         sel, w;
        sel = $urandom_range(0, 19);
        if (sel < 3)       opc = OPC_JMP;
        else if (sel < 7)  opc = OPC_JZ;
        else if (sel == 7) opc = OPC_HLT;
        else               opc = ropc();
        w = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
        do_instr(opc, rb(), w, $urandom_range(1, 4), ($urandom_range(0, 3) != 0),
                 $urandom_range(1, 3), stop);
    endtask

    initial begin
        bit stop;
        reset         = 1'b1;
        bus.run       = 1'b0;
        bus.mem_ready = 1'b0;
        bus.exec_done = 1'b0;
        bus.ir_opcode = 8'h00;
        bus.zero_flag = 1'b0;
        repeat (2) @(negedge clk);
        async_reset("reset_initial");

        // Back-to-back 5-cycle instructions, counter_enable every 5 cycles.
        for (int i = 0; i < 4; i++) do_instr(8'h01, 1'b0, 0, 1, 1'b1, 1, stop);
        do_instr(OPC_JMP, 1'b0, 0, 1, 1'b1, 1, stop);
        do_instr(OPC_JZ, 1'b0, 1, 2, 1'b1, 1, stop);
        do_instr(OPC_JZ, 1'b1, 0, 1, 1'b0, 2, stop);
        do_instr(8'h01, 1'b0, int'(WAIT_MAX) - 1, 3, 1'b0, 1, stop);  // ready on last allowed
        do_instr(8'h01, 1'b0, int'(WAIT_MAX), 1, 1'b1, 1, stop);      // timeout -> fault
        async_reset("reset_from_fault");
        do_instr(OPC_HLT, 1'b0, 0, 1, 1'b1, 1, stop);
        async_reset("reset_from_halt");

        // Reset while F_DATA drives the bus.
        cyc(V_FADDR, 1'b0, rb(), rb(), ropc(), rb());
        cyc(V_FWAIT, 1'b0, 1'b1, rb(), ropc(), rb());
        cyc(V_FDATA, 1'b0, rb(), rb(), ropc(), rb());
        async_reset("reset_in_fdata");

        // Randomized episodes, each ending on halt/fault or after a fixed length.
        for (int ep = 0; ep < 8; ep++) begin
            stop = 0;
            for (int i = 0; i < 25 && !stop; i++) rand_instr(stop);
            async_reset("reset_episode");
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
